// File: rtl/timer_tick_scheduler.sv
// Avalon-MM master that programs an interval timer, services its irq as ticks,
// and drives NUM_CH software divider channels off those ticks.
module timer_tick_scheduler #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DIV_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic [31:0]       cfg_period,
  input  logic              host_wr,
  input  logic [3:0]        host_ch,
  input  logic [DIV_W-1:0]  host_div,
  output logic [3:0]        tmr_address,
  output logic              tmr_chipselect,
  output logic              tmr_write_n,
  output logic [15:0]       tmr_writedata,
  input  logic              tmr_irq,
  output logic              running,
  output logic [NUM_CH-1:0] ch_event,
  output logic [31:0]       tick_count
);

  typedef enum logic [3:0] {
    S_IDLE, S_WP0, S_WP1, S_WP2, S_WP3, S_WCTL,
    S_RUN, S_CLR, S_CLRW, S_WSTOP, S_WSCLR
  } state_t;

  state_t            state_q, state_d;
  logic              stop_pend_q, stop_pend_d;
  logic [15:0]       per_hi_q;
  logic              cs_d, running_d;
  logic [3:0]        addr_d;
  logic [15:0]       data_d;
  logic              tick, load;
  logic [31:0]       tick_count_d;
  logic [NUM_CH-1:0] host_sel;
  logic [DIV_W-1:0]  div_q [NUM_CH];
  logic [DIV_W-1:0]  cnt_q [NUM_CH];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && !stop) state_d = S_WP0;
      S_WP0:   state_d = S_WP1;
      S_WP1:   state_d = S_WP2;
      S_WP2:   state_d = S_WP3;
      S_WP3:   state_d = S_WCTL;
      S_WCTL:  state_d = S_RUN;
      S_RUN: begin
        if (stop || stop_pend_q) state_d = S_WSTOP;
        else if (tmr_irq)        state_d = S_CLR;
      end
      S_CLR:   state_d = S_CLRW;
      S_CLRW:  state_d = S_RUN;
      S_WSTOP: state_d = S_WSCLR;
      S_WSCLR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so the access lands in the
  // same cycle the FSM enters the write state.
  always_comb begin
    cs_d   = 1'b0;
    addr_d = '0;
    data_d = '0;
    case (state_d)
      S_WP0:   begin cs_d = 1'b1; addr_d = 4'd2; data_d = cfg_period[15:0]; end
      S_WP1:   begin cs_d = 1'b1; addr_d = 4'd3; data_d = per_hi_q; end
      S_WP2:   begin cs_d = 1'b1; addr_d = 4'd4; end
      S_WP3:   begin cs_d = 1'b1; addr_d = 4'd5; end
      S_WCTL:  begin cs_d = 1'b1; addr_d = 4'd1; data_d = 16'h0007; end
      S_CLR:   begin cs_d = 1'b1; addr_d = 4'd0; end
      S_WSTOP: begin cs_d = 1'b1; addr_d = 4'd1; data_d = 16'h0008; end
      S_WSCLR: begin cs_d = 1'b1; addr_d = 4'd0; end
      default: ;
    endcase
    running_d = (state_d == S_RUN) || (state_d == S_CLR) || (state_d == S_CLRW);
  end

  always_comb begin
    stop_pend_d = stop_pend_q;
    if (state_q == S_WSTOP)
      stop_pend_d = 1'b0;
    else if (stop && (state_q inside {S_WP0, S_WP1, S_WP2, S_WP3, S_WCTL, S_CLR, S_CLRW}))
      stop_pend_d = 1'b1;
  end

  assign tick = (state_q == S_CLR);
  assign load = (state_q == S_IDLE) && (state_d == S_WP0);

  always_comb begin
    tick_count_d = tick_count;
    if (load)      tick_count_d = '0;
    else if (tick) tick_count_d = tick_count + 32'd1;
  end

  always_comb begin
    host_sel = '0;
    for (int unsigned c = 0; c < NUM_CH; c++)
      host_sel[c] = host_wr && (host_ch == 4'(c));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      stop_pend_q    <= 1'b0;
      per_hi_q       <= '0;
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_address    <= '0;
      tmr_writedata  <= '0;
      running        <= 1'b0;
      tick_count     <= '0;
    end else begin
      state_q        <= state_d;
      stop_pend_q    <= stop_pend_d;
      if (load) per_hi_q <= cfg_period[31:16];
      tmr_chipselect <= cs_d;
      tmr_write_n    <= !cs_d;
      tmr_address    <= addr_d;
      tmr_writedata  <= data_d;
      running        <= running_d;
      tick_count     <= tick_count_d;
    end
  end

  // Host write takes precedence over both the start reload and a tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ch_event <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        div_q[c] <= '0;
        cnt_q[c] <= '0;
      end
    end else begin
      ch_event <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (host_sel[c]) begin
          div_q[c] <= host_div;
          cnt_q[c] <= host_div;
        end else if (load) begin
          cnt_q[c] <= div_q[c];
        end else if (tick && (div_q[c] != '0)) begin
          if (cnt_q[c] == DIV_W'(1)) begin
            cnt_q[c]    <= div_q[c];
            ch_event[c] <= 1'b1;
          end else begin
            cnt_q[c] <= cnt_q[c] - DIV_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_timer_tick_scheduler.sv
// Directed bench for timer_tick_scheduler: bus write sequences, tick servicing,
// divider events, stop handling, wrap and asynchronous reset.
module tb_timer_tick_scheduler;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DIV_W  = 16;

  logic              clk, reset_n, start, stop, host_wr, tmr_irq;
  logic [31:0]       cfg_period;
  logic [3:0]        host_ch;
  logic [DIV_W-1:0]  host_div;
  logic [3:0]        tmr_address;
  logic              tmr_chipselect, tmr_write_n, running;
  logic [15:0]       tmr_writedata;
  logic [NUM_CH-1:0] ch_event;
  logic [31:0]       tick_count;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  timer_tick_scheduler #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .cfg_period(cfg_period), .host_wr(host_wr), .host_ch(host_ch),
    .host_div(host_div), .tmr_address(tmr_address),
    .tmr_chipselect(tmr_chipselect), .tmr_write_n(tmr_write_n),
    .tmr_writedata(tmr_writedata), .tmr_irq(tmr_irq), .running(running),
    .ch_event(ch_event), .tick_count(tick_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bus(input string tag, input logic cs, input logic [3:0] a,
                           input logic [15:0] d);
    check(tag, {10'b0, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata},
               {10'b0, cs, !cs, a, d});
  endtask

  // One irq round trip from RUN: CLR write, event cycle, back in RUN.
  task automatic do_tick(input logic [3:0] exp_ev, input logic hw,
                         input logic [3:0] hw_ch, input logic [15:0] hw_div);
    tmr_irq = 1'b1;
    step();
    check_bus("clr_bus", 1'b1, 4'd0, 16'h0000);
    check("clr_ev", 32'(ch_event), 32'h0);
    if (hw) begin
      host_wr = 1'b1; host_ch = hw_ch; host_div = hw_div;
    end
    step();
    tmr_irq = 1'b0; host_wr = 1'b0;
    check_bus("clrw_bus", 1'b0, 4'd0, 16'h0000);
    check("tick_ev", 32'(ch_event), 32'(exp_ev));
    step();
    check("run_ev", 32'(ch_event), 32'h0);
    check("run_flag", 32'(running), 32'h1);
    step();
  endtask

  task automatic start_seq(input logic [31:0] per);
    cfg_period = per;
    start = 1'b1;
    step();
    start = 1'b0;
    check_bus("wp0", 1'b1, 4'd2, per[15:0]);
    check("wp0_tc", tick_count, 32'h0);
    step(); check_bus("wp1", 1'b1, 4'd3, per[31:16]);
    step(); check_bus("wp2", 1'b1, 4'd4, 16'h0000);
    step(); check_bus("wp3", 1'b1, 4'd5, 16'h0000);
    step(); check_bus("wctl", 1'b1, 4'd1, 16'h0007);
    check("wctl_run", 32'(running), 32'h0);
    step(); check_bus("run_idle", 1'b0, 4'd0, 16'h0000);
    check("run_on", 32'(running), 32'h1);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; cfg_period = '0;
    host_wr = 1'b0; host_ch = '0; host_div = '0; tmr_irq = 1'b0;
    step(); step();
    check_bus("rst_bus", 1'b0, 4'd0, 16'h0000);
    check("rst_run", 32'(running), 32'h0);
    check("rst_ev", 32'(ch_event), 32'h0);
    check("rst_tc", tick_count, 32'h0);
    reset_n = 1'b1;
    step();

    // T1: full programming sequence
    start_seq(32'h0002_49EF);

    // T2: ch0 every tick, ch1 every third tick
    host_wr = 1'b1; host_ch = 4'd0; host_div = 16'd1;
    step();
    host_ch = 4'd1; host_div = 16'd3;
    step();
    host_wr = 1'b0;
    step();
    for (int i = 1; i <= 7; i++)
      do_tick((i % 3 == 0) ? 4'b0011 : 4'b0001, 1'b0, 4'd0, 16'd0);
    check("t2_tc", tick_count, 32'd7);

    // T4: host write coincident with the tick that would fire ch1
    do_tick(4'b0001, 1'b0, 4'd0, 16'd0);
    do_tick(4'b0001, 1'b1, 4'd1, 16'd2);
    do_tick(4'b0001, 1'b0, 4'd0, 16'd0);
    do_tick(4'b0011, 1'b0, 4'd0, 16'd0);
    check("t4_tc", tick_count, 32'd11);

    // T5: start in RUN ignored; out-of-range channel write ignored
    cfg_period = 32'h0000_1234;
    start = 1'b1;
    step();
    start = 1'b0;
    check_bus("run_start", 1'b0, 4'd0, 16'h0000);
    check("run_start_tc", tick_count, 32'd11);
    check("run_start_run", 32'(running), 32'h1);
    host_wr = 1'b1; host_ch = 4'd4; host_div = 16'd2;
    step();
    host_wr = 1'b0;
    step();

    // tick_count wrap
    force dut.tick_count = 32'hFFFF_FFFF;
    step(); step();
    release dut.tick_count;
    step();
    do_tick(4'b0001, 1'b0, 4'd0, 16'd0);
    check("wrap_tc", tick_count, 32'h0);
    do_tick(4'b0011, 1'b0, 4'd0, 16'd0);
    check("wrap_tc1", tick_count, 32'h1);

    // stop from RUN
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_bus("wstop", 1'b1, 4'd1, 16'h0008);
    check("wstop_run", 32'(running), 32'h0);
    step(); check_bus("wsclr", 1'b1, 4'd0, 16'h0000);
    step(); check_bus("stop_idle", 1'b0, 4'd0, 16'h0000);
    check("stop_run", 32'(running), 32'h0);
    tmr_irq = 1'b1;
    step(); step();
    check_bus("idle_irq", 1'b0, 4'd0, 16'h0000);
    tmr_irq = 1'b0;

    // start && stop together in IDLE
    cfg_period = 32'h0000_0100;
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check_bus("ss_idle0", 1'b0, 4'd0, 16'h0000);
    step();
    check_bus("ss_idle1", 1'b0, 4'd0, 16'h0000);
    check("ss_run", 32'(running), 32'h0);

    // T3: stop during WP2 is deferred to RUN entry
    cfg_period = 32'h0000_0007;
    start = 1'b1;
    step();
    start = 1'b0;
    check_bus("t3_wp0", 1'b1, 4'd2, 16'h0007);
    check("t3_tc", tick_count, 32'h0);
    step(); check_bus("t3_wp1", 1'b1, 4'd3, 16'h0000);
    step(); check_bus("t3_wp2", 1'b1, 4'd4, 16'h0000);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_bus("t3_wp3", 1'b1, 4'd5, 16'h0000);
    step(); check_bus("t3_wctl", 1'b1, 4'd1, 16'h0007);
    step(); check_bus("t3_run", 1'b0, 4'd0, 16'h0000);
    check("t3_run_on", 32'(running), 32'h1);
    step(); check_bus("t3_wstop", 1'b1, 4'd1, 16'h0008);
    step(); check_bus("t3_wsclr", 1'b1, 4'd0, 16'h0000);
    step(); check_bus("t3_idle", 1'b0, 4'd0, 16'h0000);
    check("t3_run_off", 32'(running), 32'h0);
    tmr_irq = 1'b1;
    step(); step();
    check_bus("t3_irq_ign", 1'b0, 4'd0, 16'h0000);
    tmr_irq = 1'b0;
    step();

    // T6: asynchronous reset during WP1, then a clean rerun
    cfg_period = 32'h0001_0020;
    start = 1'b1;
    step();
    start = 1'b0;
    check_bus("t6_wp0", 1'b1, 4'd2, 16'h0020);
    step();
    check_bus("t6_wp1", 1'b1, 4'd3, 16'h0001);
    reset_n = 1'b0;
    #1;
    check_bus("t6_rst_bus", 1'b0, 4'd0, 16'h0000);
    check("t6_rst_run", 32'(running), 32'h0);
    step(); step();
    reset_n = 1'b1;
    step();
    check_bus("t6_idle", 1'b0, 4'd0, 16'h0000);
    start_seq(32'h0003_0004);
    do_tick(4'b0000, 1'b0, 4'd0, 16'd0);
    check("t6_tc", tick_count, 32'h1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
